// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic-array weight/convolution scheduler:
// FSM state encoding, default array geometry and the active-column mask helper.
package systolic_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_COL   = 32;
  localparam int DEF_ROW   = 25;
  localparam int MASK_W    = 64;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_W   = 3'd1,
    DRAIN_W  = 3'd2,
    CONV_GO  = 3'd3,
    CONV_RUN = 3'd4,
    DONE     = 3'd5
  } sched_state_e;

  // Low n bits set; callers size-cast the result down to the column count.
  function automatic logic [MASK_W-1:0] col_mask(input logic [6:0] n);
    col_mask = (MASK_W'(1) << n) - MASK_W'(1);
  endfunction

endpackage

// File: rtl/systolic_sched.sv
// Job scheduler for the systolic array: loads K*K weight rows from the
// weight buffer, then issues num_pass conv_go pulses, one per conv_finish.
// Optional feature macro: SYSTOLIC_SCHED_PERF_EN adds the perf_cycles
// busy-cycle counter output.
// Handshake note: start is a one-cycle request that only counts in IDLE;
// conv_go is a one-cycle command and conv_finish a one-cycle completion that
// only counts in CONV_RUN; abort is honoured in any non-IDLE state and wins
// over a coincident conv_finish.
module systolic_sched
  import systolic_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int COL    = DEF_COL,
  parameter int ROW    = DEF_ROW,
  parameter int PASS_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [4:0]        weight_dim,
  input  logic [5:0]        num_filter,
  input  logic [PASS_W-1:0] num_pass,
  output logic              wbuf_rd_en,
  output logic [4:0]        wbuf_rd_addr,
  output logic [COL-1:0]    weight_en,
  output logic              conv_go,
  input  logic              conv_finish,
  output logic              busy,
  output logic              done,
  output logic              err,
`ifdef SYSTOLIC_SCHED_PERF_EN
  output logic [31:0]       perf_cycles,
`endif
  output sched_state_e      dbg_state
);

  // WIDTH is carried for integration with the array top; reject nonsense.
  if (WIDTH < 1 || PASS_W < 1) begin : g_bad_cfg
    $error("systolic_sched: WIDTH and PASS_W must be positive");
  end

  sched_state_e      state_q, state_d;
  logic [4:0]        addr_q, addr_d;
  logic [9:0]        kk_q, kk_d;
  logic [5:0]        nf_q, nf_d;
  logic [PASS_W-1:0] np_q, np_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic              rd_en_q, rd_en_d;
  logic [COL-1:0]    we_q, we_d;
  logic              go_q, go_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic [9:0]        kk_req;
  logic              cfg_ok;
  logic              start_acc;
  logic [PASS_W-1:0] pass_inc;

  // Decode the requested job and decide whether it is legal.
  always_comb begin
    kk_req    = {5'd0, weight_dim} * {5'd0, weight_dim};
    cfg_ok    = (num_filter != 6'd0) && (int'(num_filter) <= COL) &&
                (weight_dim != 5'd0) && (int'(kk_req) <= ROW) &&
                (num_pass != '0);
    start_acc = (state_q == IDLE) && start && cfg_ok;
    pass_inc  = pass_q + PASS_W'(1);
  end

  // Next-state and next-output logic; abort overrides everything at the end.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    kk_d    = kk_q;
    nf_d    = nf_q;
    np_d    = np_q;
    pass_d  = pass_q;
    rd_en_d = 1'b0;
    // Returned weight data lags the read by one cycle; the shift enable follows it.
    we_d    = rd_en_q ? COL'(col_mask({1'b0, nf_q})) : '0;
    go_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            kk_d    = kk_req;
            nf_d    = num_filter;
            np_d    = num_pass;
            addr_d  = 5'd0;
            pass_d  = '0;
            rd_en_d = 1'b1;
            state_d = LOAD_W;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD_W: begin
        if ({5'd0, addr_q} == kk_q - 10'd1) begin
          addr_d  = 5'd0;
          state_d = DRAIN_W;
        end else begin
          addr_d  = addr_q + 5'd1;
          rd_en_d = 1'b1;
        end
      end
      DRAIN_W: state_d = CONV_GO;
      CONV_GO: begin
        go_d    = 1'b1;
        state_d = CONV_RUN;
      end
      CONV_RUN: begin
        if (conv_finish) begin
          pass_d = pass_inc;
          if (pass_inc == np_q) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = CONV_GO;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      addr_d  = 5'd0;
      rd_en_d = 1'b0;
      we_d    = '0;
      go_d    = 1'b0;
      done_d  = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  // State, counters, latched config and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 5'd0;
      kk_q    <= 10'd0;
      nf_q    <= 6'd0;
      np_q    <= '0;
      pass_q  <= '0;
      rd_en_q <= 1'b0;
      we_q    <= '0;
      go_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      kk_q    <= kk_d;
      nf_q    <= nf_d;
      np_q    <= np_d;
      pass_q  <= pass_d;
      rd_en_q <= rd_en_d;
      we_q    <= we_d;
      go_q    <= go_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

`ifdef SYSTOLIC_SCHED_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Busy-cycle count for the current job, saturating, held after completion.
  always_comb begin
    perf_d = perf_q;
    if (start_acc)                   perf_d = 32'd0;
    else if (busy_q && perf_q != '1) perf_d = perf_q + 32'd1;
  end

  // Perf counter register.
  always_ff @(posedge clk) begin
    if (rst) perf_q <= 32'd0;
    else     perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`endif

  assign wbuf_rd_en   = rd_en_q;
  assign wbuf_rd_addr = addr_q;
  assign weight_en    = we_q;
  assign conv_go      = go_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign dbg_state    = state_q;

endmodule
